// File: rtl/memory_dp_sync.sv
`default_nettype none
// ============================================================================
// Module   : memory_dp_sync
// Brief    : Dual-port synchronous storage array with post-reset clear sweep,
//            registered read data (latency 1 or 2) and selectable collision mode.
// Revision : 1.0
// ============================================================================
module memory_dp_sync #(
    parameter int                    DATA_WIDTH   = 9,
    parameter int                    ADDR_WIDTH   = 4,
    parameter int                    READ_LATENCY = 1,
    parameter int                    BYPASS       = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  init_busy
);

    localparam int              c_DEPTH = 2 ** ADDR_WIDTH;
    localparam int              c_CW    = ADDR_WIDTH + 1;
    localparam logic [c_CW-1:0] c_LAST  = c_CW'(c_DEPTH - 1);
    localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                r_state;
    logic [c_CW-1:0]       r_cnt;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;

    logic                  w_ready;
    logic                  w_wen;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_rd_req;
    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_stage_valid;
    logic [DATA_WIDTH-1:0] w_stage_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                ST_READY: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign w_ready = (r_state == ST_READY);

    // The sweep owns the write port until READY; reset itself never writes.
    always_comb begin
        w_wen   = 1'b0;
        w_waddr = write_addr;
        w_wdata = data_in;
        if (!reset) begin
            if (!w_ready) begin
                w_wen   = 1'b1;
                w_waddr = r_cnt[ADDR_WIDTH-1:0];
                w_wdata = INIT_VALUE;
            end else if (we) begin
                w_wen = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wen) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign w_rd_req  = w_ready && re && !reset;
    assign w_collide = we && (write_addr == read_addr);
    assign w_rd_data = ((BYPASS != 0) && w_collide) ? data_in : r_mem[read_addr];

    generate
        if (READ_LATENCY >= 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] r_pipe_data;
            logic                  r_pipe_valid;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pipe_valid <= 1'b0;
                    r_pipe_data  <= '0;
                end else begin
                    r_pipe_valid <= w_rd_req;
                    if (w_rd_req) begin
                        r_pipe_data <= w_rd_data;
                    end
                end
            end

            assign w_stage_valid = r_pipe_valid;
            assign w_stage_data  = r_pipe_data;
        end else begin : g_lat1
            assign w_stage_valid = w_rd_req;
            assign w_stage_data  = w_rd_data;
        end
    endgenerate

    // data_out only moves on a completed read, so it holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_valid <= 1'b0;
            r_data_out   <= '0;
        end else begin
            r_data_valid <= w_stage_valid;
            if (w_stage_valid) begin
                r_data_out <= w_stage_data;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign init_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_memory_dp_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_dp_sync
// Brief    : Self-checking bench: latency-1/write-first and latency-2/read-first
//            instances driven in parallel against a behavioural memory model.
// Revision : 1.0
// ============================================================================
module tb_memory_dp_sync;

    logic       clk = 1'b0;
    logic       reset;
    logic       we;
    logic [3:0] write_addr;
    logic [8:0] data_in;
    logic       re;
    logic [3:0] read_addr;

    logic [8:0] do_a, do_b;
    logic       dv_a, dv_b, busy_a, busy_b;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [8:0] m_mem [16];
    logic       m_busy;
    int         m_cnt;
    logic       m_dva, m_dvb, m_pv;
    logic [8:0] m_doa, m_dob, m_pd;

    always #5 clk = ~clk;

    memory_dp_sync u_a (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .write_addr (write_addr),
        .data_in    (data_in),
        .re         (re),
        .read_addr  (read_addr),
        .data_out   (do_a),
        .data_valid (dv_a),
        .init_busy  (busy_a)
    );

    memory_dp_sync #(
        .READ_LATENCY (2),
        .BYPASS       (0)
    ) u_b (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .write_addr (write_addr),
        .data_in    (data_in),
        .re         (re),
        .read_addr  (read_addr),
        .data_out   (do_b),
        .data_valid (dv_b),
        .init_busy  (busy_b)
    );

    logic [21:0] obs;
    assign obs = {busy_a, dv_a, do_a, busy_b, dv_b, do_b};

    function automatic logic [21:0] exp_vec();
        return {m_busy, m_dva, m_doa, m_busy, m_dvb, m_dob};
    endfunction

    // One clock: update the model from the inputs seen at the edge, return at negedge.
    task automatic step();
        logic       rd;
        logic [8:0] ra, rb;
        @(posedge clk);
        if (reset) begin
            m_busy = 1'b1; m_cnt = 0;
            m_dva = 1'b0; m_doa = '0; m_dvb = 1'b0; m_dob = '0; m_pv = 1'b0; m_pd = '0;
        end else begin
            rd = !m_busy && re;
            rb = m_mem[read_addr];
            ra = (we && write_addr == read_addr) ? data_in : rb;
            m_dvb = m_pv;
            if (m_pv) m_dob = m_pd;
            m_pv = rd; m_pd = rb;
            m_dva = rd;
            if (rd) m_doa = ra;
            if (m_busy) begin
                m_mem[m_cnt] = 9'h000;
                m_cnt++;
                if (m_cnt == 16) m_busy = 1'b0;
            end else if (we) begin
                m_mem[write_addr] = data_in;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        we = 1'b0; re = 1'b0; write_addr = '0; read_addr = '0; data_in = '0;
    endtask

    // Steps until init_busy drops (bounded); returns busy cycles including the current one.
    task automatic count_busy(output int n);
        n = busy_a ? 1 : 0;
        for (int k = 0; k < 40 && busy_a; k++) begin
            step();
            if (busy_a) n++;
        end
    endtask

    task automatic test_reset();
        int nb;
        idle_inputs();
        reset = 1'b1;
        step();
        if (obs !== {1'b1, 1'b0, 9'h000, 1'b1, 1'b0, 9'h000}) begin
            n_fail++; $display("FAIL reset_state: got %h want %h", obs, {1'b1, 1'b0, 9'h000, 1'b1, 1'b0, 9'h000});
        end
        n_cmp++;
        reset = 1'b0;
        count_busy(nb);
        if (nb !== 16 || busy_b !== 1'b0) begin
            n_fail++; $display("FAIL init_length: got %0d cycles (busy_b=%b) want 16", nb, busy_b);
        end
        n_cmp++;
        for (int i = 0; i < 16; i++) begin
            re = 1'b1; read_addr = 4'(i);
            step();
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL init_read_model: got %h want %h", obs, exp_vec());
            end
            n_cmp++;
            if (dv_a !== 1'b1 || do_a !== 9'h000) begin
                n_fail++; $display("FAIL init_read_a%0d: dv=%b data=%h want dv=1 data=000", i, dv_a, do_a);
            end
            n_cmp++;
        end
        re = 1'b0;
        step();
        if (dv_b !== 1'b1 || do_b !== 9'h000) begin
            n_fail++; $display("FAIL init_read_b_last: dv=%b data=%h want dv=1 data=000", dv_b, do_b);
        end
        n_cmp++;
        step();
    endtask

    task automatic test_write_read();
        idle_inputs();
        we = 1'b1; write_addr = 4'd3; data_in = 9'h1A5;
        step();
        idle_inputs();
        re = 1'b1; read_addr = 4'd3;
        step();
        if ({dv_a, do_a, dv_b} !== {1'b1, 9'h1A5, 1'b0}) begin
            n_fail++; $display("FAIL wr_rd_lat1: got dv_a=%b do_a=%h dv_b=%b want 1 1a5 0", dv_a, do_a, dv_b);
        end
        n_cmp++;
        re = 1'b0;
        step();
        if ({dv_a, do_a, dv_b, do_b} !== {1'b0, 9'h1A5, 1'b1, 9'h1A5}) begin
            n_fail++; $display("FAIL wr_rd_lat2: got %b %h %b %h want 0 1a5 1 1a5", dv_a, do_a, dv_b, do_b);
        end
        n_cmp++;
        step();
        if ({dv_a, do_a, dv_b, do_b} !== {1'b0, 9'h1A5, 1'b0, 9'h1A5}) begin
            n_fail++; $display("FAIL wr_rd_hold: got %b %h %b %h want 0 1a5 0 1a5", dv_a, do_a, dv_b, do_b);
        end
        n_cmp++;
    endtask

    task automatic test_collision();
        idle_inputs();
        we = 1'b1; write_addr = 4'd7; data_in = 9'h011;
        step();
        re = 1'b1; read_addr = 4'd7; data_in = 9'h0FF;
        step();
        idle_inputs();
        if (dv_a !== 1'b1 || do_a !== 9'h0FF) begin
            n_fail++; $display("FAIL collide_write_first: dv=%b data=%h want 1 0ff", dv_a, do_a);
        end
        n_cmp++;
        step();
        if (dv_b !== 1'b1 || do_b !== 9'h011) begin
            n_fail++; $display("FAIL collide_read_first: dv=%b data=%h want 1 011", dv_b, do_b);
        end
        n_cmp++;
        re = 1'b1; read_addr = 4'd7;
        step();
        re = 1'b0;
        step();
        if (do_a !== 9'h0FF || do_b !== 9'h0FF || dv_b !== 1'b1) begin
            n_fail++; $display("FAIL collide_after: do_a=%h do_b=%h dv_b=%b want 0ff 0ff 1", do_a, do_b, dv_b);
        end
        n_cmp++;
    endtask

    task automatic test_streaming();
        logic [8:0] qa[$], qb[$];
        int fa, la, fb, lb;
        fa = -1; la = -1; fb = -1; lb = -1;
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; write_addr = 4'(i); data_in = 9'(i * 3);
            step();
        end
        idle_inputs();
        for (int t = 0; t < 19; t++) begin
            re = (t < 16); read_addr = 4'(t);
            step();
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL stream_model t=%0d: got %h want %h", t, obs, exp_vec());
            end
            n_cmp++;
            if (dv_a) begin qa.push_back(do_a); if (fa < 0) fa = t; la = t; end
            if (dv_b) begin qb.push_back(do_b); if (fb < 0) fb = t; lb = t; end
        end
        if (qa.size() != 16 || qb.size() != 16 || la - fa != 15 || lb - fb != 15 || fb - fa != 1) begin
            n_fail++; $display("FAIL stream_shape: na=%0d nb=%0d spanA=%0d spanB=%0d skew=%0d want 16 16 15 15 1",
                               qa.size(), qb.size(), la - fa, lb - fb, fb - fa);
        end
        n_cmp++;
        for (int i = 0; i < 16 && i < qa.size() && i < qb.size(); i++) begin
            if (qa[i] !== 9'(i * 3) || qb[i] !== 9'(i * 3)) begin
                n_fail++; $display("FAIL stream_data%0d: a=%h b=%h want %h", i, qa[i], qb[i], 9'(i * 3));
            end
            n_cmp++;
        end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int t = 0; t < 300; t++) begin
            we         = 1'($urandom);
            re         = 1'($urandom);
            write_addr = 4'($urandom_range(0, 3));
            read_addr  = 4'($urandom_range(0, 3));
            data_in    = 9'($urandom);
            step();
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL random_model t=%0d: got %h want %h", t, obs, exp_vec());
            end
            n_cmp++;
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_reset_mid();
        int nb;
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        count_busy(nb);
        if (nb !== 16) begin
            n_fail++; $display("FAIL reset_mid_init: got %0d busy cycles want 16", nb);
        end
        n_cmp++;
        re = 1'b1; read_addr = 4'd1;
        step();
        read_addr = 4'd2;
        step();
        re = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        if ({dv_a, do_a, dv_b, do_b, busy_a} !== {1'b0, 9'h000, 1'b0, 9'h000, 1'b1}) begin
            n_fail++; $display("FAIL reset_flush: got %b %h %b %h busy=%b want 0 000 0 000 1", dv_a, do_a, dv_b, do_b, busy_a);
        end
        n_cmp++;
        step();
        if (dv_a !== 1'b0 || dv_b !== 1'b0) begin
            n_fail++; $display("FAIL reset_flush_late: dv_a=%b dv_b=%b want 0 0", dv_a, dv_b);
        end
        n_cmp++;
        count_busy(nb);
    endtask

    task automatic test_init_access();
        int nd;
        nd = 0;
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step();
        we = 1'b1; write_addr = 4'd2; data_in = 9'h155; re = 1'b1; read_addr = 4'd2;
        for (int k = 0; k < 40 && busy_a; k++) begin
            step();
            if (dv_a || dv_b) nd++;
        end
        idle_inputs();
        if (nd !== 0 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL init_access_valid: got %0d pulses busy=%b want 0 0", nd, busy_a);
        end
        n_cmp++;
        re = 1'b1; read_addr = 4'd2;
        step();
        re = 1'b0;
        if (dv_a !== 1'b1 || do_a !== 9'h000) begin
            n_fail++; $display("FAIL init_access_a: dv=%b data=%h want 1 000", dv_a, do_a);
        end
        n_cmp++;
        step();
        if (dv_b !== 1'b1 || do_b !== 9'h000) begin
            n_fail++; $display("FAIL init_access_b: dv=%b data=%h want 1 000", dv_b, do_b);
        end
        n_cmp++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = 9'h000;
        m_busy = 1'b1; m_cnt = 0;
        m_dva = 1'b0; m_dvb = 1'b0; m_pv = 1'b0;
        m_doa = '0; m_dob = '0; m_pd = '0;
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_collision();
        test_streaming();
        test_random();
        test_reset_mid();
        test_init_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
